// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan driver: code values,
// segment bit positions and the code-to-pattern decoder.
package seg_pkg;

  // Non-numeric digit codes
  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;
  localparam logic [3:0] CODE_A     = 4'd12;
  localparam logic [3:0] CODE_D     = 4'd13;
  localparam logic [3:0] CODE_E     = 4'd14;
  localparam logic [3:0] CODE_F     = 4'd15;

  // Segment bit order within a pattern byte: {a,b,c,d,e,f,g,dp}
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Active-high segment pattern for a code, with the decimal point ORed in
  function automatic logic [7:0] seg_decode(input logic [3:0] code, input logic dp);
    logic [7:0] p;
    case (code)
      4'd0:       p = 8'hFC;
      4'd1:       p = 8'h60;
      4'd2:       p = 8'hDA;
      4'd3:       p = 8'hF2;
      4'd4:       p = 8'h66;
      4'd5:       p = 8'hB6;
      4'd6:       p = 8'hBE;
      4'd7:       p = 8'hE0;
      4'd8:       p = 8'hFE;
      4'd9:       p = 8'hF6;
      CODE_MINUS: p = 8'h02;
      CODE_BLANK: p = 8'h00;
      CODE_A:     p = 8'hEE;
      CODE_D:     p = 8'h7A;
      CODE_E:     p = 8'h9E;
      default:    p = 8'h8E;
    endcase
    p[SEG_DP] = p[SEG_DP] | dp;
    return p;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bus between the calculator core (master) and the scan driver (slave).
//
// Handshake: load is a single-cycle capture strobe with no back-pressure;
// the driver always accepts it. Data captured by load becomes visible at
// the first frame_start after the next frame wrap. frame_start is a
// one-cycle pulse on the first output cycle of each frame and has no
// acknowledge.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic                      en;
  logic [4*NUM_DIGITS-1:0]   codes;
  logic [NUM_DIGITS-1:0]     dp_mask;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic                      lz_en;
  logic                      load;
  logic [NUM_DIGITS-1:0]     an;
  logic [7:0]                duan;
  logic [7:0]                duan1;
  logic                      frame_start;

  modport master (
    output en, codes, dp_mask, blink_mask, lz_en, load,
    input  an, duan, duan1, frame_start
  );

  modport slave (
    input  en, codes, dp_mask, blink_mask, lz_en, load,
    output an, duan, duan1, frame_start
  );
endinterface

// File: rtl/seg_blink_gen.sv
// Blink phase generator: toggles blink_phase every BLINK_DIV enabled cycles.
module seg_blink_gen #(
  parameter int BLINK_DIV = 250
) (
  input  logic clk_scan,
  input  logic rst_n,
  input  logic en,
  output logic blink_phase
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;

  // Half-period counter; phase flips when the counter wraps
  always_ff @(posedge clk_scan) begin
    if (!rst_n) begin
      cnt         <= '0;
      blink_phase <= 1'b1;
    end else if (en) begin
      if (cnt == CNT_MAX) begin
        cnt         <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with tear-free staging/shadow buffers,
// leading-zero suppression, blinking and an anti-ghost blanking gap.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int BANK_SPLIT = 4,
  parameter int DWELL      = 2,
  parameter int GAP        = 1,
  parameter int BLINK_DIV  = 250
) (
  input  logic            clk_scan,
  input  logic            rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int SW = $clog2(NUM_DIGITS);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW-1:0] SLOT_TOP  = SW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] DWELL_TOP = DW'(DWELL - 1);

  // Scan position
  logic [SW-1:0] slot;
  logic [DW-1:0] dwell;
  logic          slot_end;
  logic          frame_wrap;
  logic          xfer;

  // Staging (written by load) and shadow (displayed) buffers
  logic [4*NUM_DIGITS-1:0] stg_codes, shd_codes;
  logic [NUM_DIGITS-1:0]   stg_dp, shd_dp;
  logic [NUM_DIGITS-1:0]   stg_blink, shd_blink;
  logic                    stg_lz, shd_lz;
  logic                    pending;

  logic                    blink_phase;
  logic [NUM_DIGITS-1:0]   dp_le;
  logic [NUM_DIGITS-1:0]   lz_sup;

  logic [NUM_DIGITS-1:0]   an_d, an_q;
  logic [7:0]              duan_d, duan_q, duan1_d, duan1_q, pat;
  logic [3:0]              cur_code;
  logic                    fs_d, fs_q;

  assign slot_end   = (dwell == DWELL_TOP);
  assign frame_wrap = slot_end && (slot == '0);
  assign xfer       = bus.en && frame_wrap && pending;

  seg_blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk_scan    (clk_scan),
    .rst_n       (rst_n),
    .en          (bus.en),
    .blink_phase (blink_phase)
  );

  // Slot/dwell counters: scan from the top digit down, freeze while disabled
  always_ff @(posedge clk_scan) begin
    if (!rst_n) begin
      slot  <= SLOT_TOP;
      dwell <= '0;
    end else if (bus.en) begin
      if (slot_end) begin
        dwell <= '0;
        slot  <= (slot == '0) ? SLOT_TOP : slot - 1'b1;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  // Staging capture; a load on the wrap edge keeps pending for the next frame
  always_ff @(posedge clk_scan) begin
    if (!rst_n) begin
      stg_codes <= {NUM_DIGITS{CODE_BLANK}};
      stg_dp    <= '0;
      stg_blink <= '0;
      stg_lz    <= 1'b0;
      pending   <= 1'b0;
    end else if (bus.load) begin
      stg_codes <= bus.codes;
      stg_dp    <= bus.dp_mask;
      stg_blink <= bus.blink_mask;
      stg_lz    <= bus.lz_en;
      pending   <= 1'b1;
    end else if (xfer) begin
      pending <= 1'b0;
    end
  end

  // Shadow update only at the frame wrap so a frame never mixes old and new data
  always_ff @(posedge clk_scan) begin
    if (!rst_n) begin
      shd_codes <= {NUM_DIGITS{CODE_BLANK}};
      shd_dp    <= '0;
      shd_blink <= '0;
      shd_lz    <= 1'b0;
    end else if (xfer) begin
      shd_codes <= stg_codes;
      shd_dp    <= stg_dp;
      shd_blink <= stg_blink;
      shd_lz    <= stg_lz;
    end
  end

  // dp_le[i]: some decimal point is set at index i or below
  always_comb begin
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      acc      = acc | shd_dp[i];
      dp_le[i] = acc;
    end
  end

  // Leading-zero suppression: a zero is blanked while everything above it is
  // zero, minus or blank and no decimal point sits at or below it
  always_comb begin
    logic       higher_ok;
    logic [3:0] c;
    higher_ok = 1'b1;
    lz_sup    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      c         = shd_codes[4*i +: 4];
      lz_sup[i] = shd_lz && (i > 0) && (c == 4'd0) && higher_ok && !dp_le[i];
      higher_ok = higher_ok && ((c == 4'd0) || (c == CODE_MINUS) || (c == CODE_BLANK));
    end
  end

  // Next output values from the current scan position and shadow contents
  always_comb begin
    an_d     = '1;
    duan_d   = '0;
    duan1_d  = '0;
    pat      = '0;
    cur_code = shd_codes[{slot, 2'b00} +: 4];
    fs_d     = bus.en && (slot == SLOT_TOP) && (dwell == '0);
    if (bus.en && !((GAP != 0) && slot_end)) begin
      an_d = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << slot);
      pat  = seg_decode(cur_code, shd_dp[slot]);
      if (lz_sup[slot] || (shd_blink[slot] && !blink_phase)) begin
        pat = '0;
      end
      if (int'(slot) < BANK_SPLIT) begin
        duan_d = pat;
      end else begin
        duan1_d = pat;
      end
    end
  end

  // Registered outputs, one cycle behind the scan counters
  always_ff @(posedge clk_scan) begin
    if (!rst_n) begin
      an_q    <= '1;
      duan_q  <= '0;
      duan1_q <= '0;
      fs_q    <= 1'b0;
    end else begin
      an_q    <= an_d;
      duan_q  <= duan_d;
      duan1_q <= duan1_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.duan        = duan_q;
  assign bus.duan1       = duan1_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a cycle-level reference model pushes the
// expected output of every clock edge into exp_q; a monitor pops and
// compares on the falling edge.
module tb_seg_scan_driver;

  localparam int N          = 8;
  localparam int BANK_SPLIT = 4;
  localparam int DWELL      = 2;
  localparam int GAP        = 1;
  localparam int BLINK_DIV  = 4;
  localparam int FRAME      = N * DWELL;
  localparam int EW         = N + 8 + 8 + 1;

  // ---------------- clock / reset ----------------
  logic clk_scan = 1'b0;
  logic rst_n;
  always #5 clk_scan = ~clk_scan;

  seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seg_scan_driver #(
    .NUM_DIGITS (N),
    .BANK_SPLIT (BANK_SPLIT),
    .DWELL      (DWELL),
    .GAP        (GAP),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .clk_scan (clk_scan),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  // ---------------- reference model ----------------
  logic [7:0] seg_tab [0:15] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'h02, 8'h00, 8'hEE, 8'h7A, 8'h9E, 8'h8E};

  logic [EW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  int         m_scan_ticks;   // enabled cycles since reset
  int         m_blink_ticks;
  logic [3:0] m_stg [N];
  logic [3:0] m_shd [N];
  logic [N-1:0] m_stg_dp, m_shd_dp, m_stg_bl, m_shd_bl;
  logic       m_stg_lz, m_shd_lz, m_pending;

  function automatic bit lz_blank(int i);
    if (!m_shd_lz || i == 0 || m_shd[i] != 4'd0) return 1'b0;
    for (int j = i + 1; j < N; j++)
      if (!(m_shd[j] inside {4'd0, 4'd10, 4'd11})) return 1'b0;
    for (int j = 0; j <= i; j++)
      if (m_shd_dp[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic [N-1:0] an_e;
    logic [7:0]   d0, d1, pat;
    logic         fs, phase_hi, wrap;
    int           pos, slot;
    bit           gap;
    if (!rst_n) begin
      exp_q.push_back({{N{1'b1}}, 8'h00, 8'h00, 1'b0});
      m_scan_ticks  = 0;
      m_blink_ticks = 0;
      for (int i = 0; i < N; i++) begin
        m_stg[i] = 4'd11;
        m_shd[i] = 4'd11;
      end
      m_stg_dp = '0; m_shd_dp = '0; m_stg_bl = '0; m_shd_bl = '0;
      m_stg_lz = 1'b0; m_shd_lz = 1'b0; m_pending = 1'b0;
      return;
    end
    pos      = m_scan_ticks % FRAME;
    slot     = N - 1 - pos / DWELL;
    gap      = (GAP == 1) && (pos % DWELL == DWELL - 1);
    phase_hi = ((m_blink_ticks / BLINK_DIV) % 2) == 0;
    an_e = '1; d0 = 8'h00; d1 = 8'h00;
    if (bus.en && !gap) begin
      an_e[slot] = 1'b0;
      pat = seg_tab[m_shd[slot]];
      if (m_shd_dp[slot]) pat[0] = 1'b1;
      if (lz_blank(slot) || (m_shd_bl[slot] && !phase_hi)) pat = 8'h00;
      if (slot < BANK_SPLIT) d0 = pat;
      else d1 = pat;
    end
    fs = bus.en && (pos == 0);
    exp_q.push_back({an_e, d0, d1, fs});
    // state advance for this edge
    wrap = bus.en && (pos == FRAME - 1);
    if (wrap && m_pending) begin
      m_shd = m_stg;
      m_shd_dp = m_stg_dp; m_shd_bl = m_stg_bl; m_shd_lz = m_stg_lz;
    end
    if (bus.load) begin
      for (int i = 0; i < N; i++) m_stg[i] = bus.codes[4*i +: 4];
      m_stg_dp = bus.dp_mask; m_stg_bl = bus.blink_mask; m_stg_lz = bus.lz_en;
      m_pending = 1'b1;
    end else if (wrap) begin
      m_pending = 1'b0;
    end
    if (bus.en) begin
      m_scan_ticks++;
      m_blink_ticks++;
    end
  endtask

  always @(posedge clk_scan) model_edge();

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_scan) begin
    logic [EW-1:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {bus.an, bus.duan, bus.duan1, bus.frame_start};
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL out_cmp t=%0t got an=%b duan=%h duan1=%h fs=%b, expected an=%b duan=%h duan1=%h fs=%b",
                 $time, g[EW-1 -: N], g[16:9], g[8:1], g[0], e[EW-1 -: N], e[16:9], e[8:1], e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_scan);
  endtask

  task automatic do_load(input logic [4*N-1:0] c, input logic [N-1:0] dp,
                         input logic [N-1:0] bl, input logic lz);
    bus.codes      = c;
    bus.dp_mask    = dp;
    bus.blink_mask = bl;
    bus.lz_en      = lz;
    bus.load       = 1'b1;
    @(negedge clk_scan);
    bus.load       = 1'b0;
  endtask

  // Return at a falling edge whose following rising edge is the frame wrap
  task automatic wait_wrap();
    int k;
    k = 0;
    while ((m_scan_ticks % FRAME) != FRAME - 1 && k < 2 * FRAME) begin
      @(negedge clk_scan);
      k++;
    end
    if (k >= 2 * FRAME) begin
      n_vec++;
      n_err++;
      $display("FAIL wrap_wait no wrap edge within %0d cycles, required one", k);
    end
  endtask

  function automatic logic [4*N-1:0] rand_codes();
    logic [4*N-1:0] c;
    for (int i = 0; i < N; i++)
      c[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return c;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_n          = 1'b0;
    bus.en         = 1'b1;
    bus.load       = 1'b0;
    bus.codes      = '0;
    bus.dp_mask    = '0;
    bus.blink_mask = '0;
    bus.lz_en      = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);

    // plain digits 7..0
    do_load(32'h7654_3210, 8'h00, 8'h00, 1'b0);
    tick(3 * FRAME);
    // leading-zero suppression, then with a decimal point on digit 5
    do_load(32'h0001_2300, 8'h00, 8'h00, 1'b1);
    tick(2 * FRAME);
    do_load(32'h0001_2300, 8'h20, 8'h00, 1'b1);
    tick(2 * FRAME);
    // minus followed by suppressed zeros
    do_load(32'hA000_0005, 8'h00, 8'h00, 1'b1);
    tick(2 * FRAME);
    // mid-frame loads, last one wins
    tick(5);
    do_load(rand_codes(), 8'h00, 8'h00, 1'b0);
    tick(2);
    do_load(32'h89AB_CDEF, 8'h81, 8'h00, 1'b0);
    tick(2 * FRAME);
    // load exactly on the wrap edge
    wait_wrap();
    do_load(32'hFEDC_BA98, 8'h00, 8'h00, 1'b0);
    tick(3 * FRAME);
    // blink on digit 0
    do_load(32'h7654_3210, 8'h00, 8'h01, 1'b0);
    tick(4 * FRAME);
    // enable freeze and resume
    bus.en = 1'b0; tick(7);
    bus.en = 1'b1; tick(5);
    bus.en = 1'b0; tick(3);
    bus.en = 1'b1; tick(FRAME);
    // reset mid-frame with pending data
    tick(5);
    do_load(32'h1234_5678, 8'h00, 8'h00, 1'b0);
    tick(2);
    rst_n = 1'b0; tick(1);
    rst_n = 1'b1; tick(2 * FRAME);

    // randomized traffic
    repeat (400) begin
      bus.en = ($urandom_range(0, 9) != 0);
      rst_n  = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 15) == 0) begin
        bus.codes      = rand_codes();
        bus.dp_mask    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
        bus.blink_mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
        bus.lz_en      = 1'($urandom_range(0, 1));
        bus.load       = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk_scan);
    end
    bus.load = 1'b0;
    bus.en   = 1'b1;
    rst_n    = 1'b1;
    tick(2 * FRAME);

    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain got %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed 7-segment scan driver, successor to the calculator's fixed 8-digit display driver. It takes per-digit codes, decimal-point, and blink masks as flat vectors from the calculator core. Inputs pass through a load/staging/shadow buffer so updates never tear mid-frame. The block generates its own blink phase, leading-zero suppression, and anti-ghost blanking gap, and drives anodes plus two segment banks.

## Interface
Parameters:
- NUM_DIGITS, 8: digits scanned; 2..16.
- BANK_SPLIT, 4: digit indices below this drive `duan`; the rest drive `duan1`.
- DWELL, 2: clk_scan cycles per digit slot; ≥1.
- GAP, 1: when 1, the last cycle of each slot is blanked; requires DWELL ≥ 2.
- BLINK_DIV, 250: clk_scan cycles per blink half-period; ≥1.

Ports:
- clk_scan  in  1  single scan clock (1 kHz on the board).
- rst_n  in  1  reset; one clock, reset synchronous, active-low.
- en  in  1  scan enable; 0 blanks the display (an all-ones, segments 0) and freezes the counters.
- codes  in  4*NUM_DIGITS  digit i at [4i+:4]; digit 0 is rightmost.
- dp_mask  in  NUM_DIGITS  decimal point per digit.
- blink_mask  in  NUM_DIGITS  digits that blink.
- lz_en  in  1  leading-zero suppression enable.
- load  in  1  capture strobe for codes, dp_mask, blink_mask and lz_en.
- an  out  NUM_DIGITS  anode select, active-low, one-hot-zero.
- duan  out  8  right-bank segments {a,b,c,d,e,f,g,dp}, active-high.
- duan1  out  8  left-bank segments, same format.
- frame_start  out  1  one-cycle pulse on the first output cycle of each frame.

## Operation
- Code table:
  - 0–9: digits.
  - 10: minus.
  - 11: blank.
  - 12: A.
  - 13: d.
  - 14: E.
  - 15: F.
- dp ORs bit 0 into the pattern.
- Scan order is digit NUM_DIGITS-1 down to 0, then wraps. Each slot lasts DWELL cycles.
- Only the active digit's bank carries a pattern; the other bank is 0.
- Buffering:
  - `load`=1 writes the inputs into staging and sets `pending`.
  - On the slot wrap edge (digit 0 → NUM_DIGITS-1), if `pending` is set, staging is copied to shadow and `pending` clears.
  - If `load` coincides with the wrap edge, the transfer uses the old staging and `pending` stays set, so the new data lands in the next frame.
  - Repeated loads within a frame: the last one wins.
- Leading-zero suppression: digit i (i>0) is blanked when all of the following hold:
  - lz_en is set;
  - code==0;
  - every higher digit's code is in {0,10,11};
  - no dp_mask bit is set at index ≤ i.
  - Digit 0 is never suppressed.
- Blink:
  - The counter wraps at BLINK_DIV-1 and toggles `blink_phase` on the wrap.
  - While phase=0, digits in blink_mask output 0 segments; their anode stays active.
  - The blink counter runs whenever en=1.
- GAP=1: in the last dwell cycle of a slot, an is all-ones and segments are 0.

## Timing
- Reset (rst_n low at a clk_scan edge) sets:
  - an all-ones, duan/duan1 = 0, frame_start = 0;
  - shadow and staging codes = 11, masks = 0, lz_en = 0, pending = 0;
  - slot = NUM_DIGITS-1, dwell = 0, blink counter = 0, blink_phase = 1.
- Reset mid-frame behaves identically and discards pending data.
- All outputs are registered, one cycle behind the slot/dwell counters.
- First output after release: the edge where rst_n is first sampled high shows digit NUM_DIGITS-1 with frame_start=1.
- Frame length = NUM_DIGITS × DWELL cycles.
- `load` to visible: at most one frame plus one cycle, and exactly at the next frame_start.
- en falling: outputs blank on the next edge. en rising: the scan resumes from the frozen slot and dwell.

## Structure
- Shared package `seg_pkg`:
  - code localparams (CODE_MINUS=10, CODE_BLANK=11, …);
  - the `seg_decode(code, dp)` function returning 8 bits;
  - segment bit-order constants.
- Sub-module `seg_blink_gen` (BLINK_DIV counter plus phase flop, with clk_scan, rst_n, en). The rest stays flat.

## Test plan
- NUM_DIGITS=8, DWELL=2, GAP=1. Load codes 7..0, release reset → an steps 01111111 … 11111110. Each digit is visible 1 cycle then blank 1 cycle. frame_start occurs every 16 cycles. Digit 7 shows duan1=8'hE0 and duan=0.
- Load 0,0,0,1,2,3,0,0 (digit7..0) with lz_en=1 and no dp → digits 7–5 blank, digits 1 and 0 show `0`. Add dp_mask[5]=1 → digit 5 shows 8'hFD.
- Load minus,0,0,0,0,0,0,5 with lz_en=1 → minus visible, digits 6–1 blank, digit 0 shows 8'hB6.
- Assert load mid-frame → shadow unchanged until the next frame_start, then new codes appear. Assert load on the wrap edge → data appears one frame later.
- BLINK_DIV=4, blink_mask=8'h01 → digit 0 segments alternate visible/zero every 4 cycles while its anode keeps strobing.
- Assert rst_n=0 mid-frame with pending=1 → next edge an=all-ones. After release, all digits blank (code 11) and frame_start is asserted on the first edge.
